// File: rtl/syn_acache_fetch_sqncr.sv
`default_nettype none
// ============================================================================
// Module   : syn_acache_fetch_sqncr
// Purpose  : Fetches one PCM frame from the audio cache read port in natural
//            or bit-reversed address order. Hides the fixed RAM read latency
//            and streams samples to the FFT front end over valid/ready, with
//            a credit-limited skid FIFO so backpressure never loses data.
// Revision : 1.0  initial release
// ============================================================================
module syn_acache_fetch_sqncr #(
    parameter int P_PCM_RAM_ADDR_W = 7,
    parameter int P_PCM_RAM_DATA_W = 32,
    parameter int P_RD_LAT         = 2,
    parameter int P_FIFO_DEPTH     = 4
) (
    input  logic                        clk_ir,
    input  logic                        rst_il,
    input  logic                        pcm_data_rdy_oh,
    input  logic                        fetch_en,
    input  logic                        bit_rev_en,
    output logic                        mem_rden,
    output logic [P_PCM_RAM_ADDR_W-1:0] mem_addr,
    input  logic [P_PCM_RAM_DATA_W-1:0] mem_rdata,
    output logic [P_PCM_RAM_DATA_W-1:0] smpl_data,
    output logic [P_PCM_RAM_ADDR_W-1:0] smpl_idx,
    output logic                        smpl_last,
    output logic                        smpl_valid,
    input  logic                        smpl_ready,
    output logic                        busy,
    output logic                        ovrn_err_oh,
    output logic [15:0]                 frame_cnt
);

    localparam int AW = P_PCM_RAM_ADDR_W;
    localparam int DW = P_PCM_RAM_DATA_W;
    localparam int PW = $clog2(P_FIFO_DEPTH);
    localparam int CW = $clog2(P_FIFO_DEPTH) + 1;
    localparam logic [AW-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   rd_ptr;
    logic            rev_f;
    logic [CW-1:0]   inflight_cnt;
    logic [CW-1:0]   fifo_cnt;
    logic [PW-1:0]   wr_pos;
    logic [PW-1:0]   rd_pos;
    logic            pipe_vld [P_RD_LAT];
    logic [AW-1:0]   pipe_idx [P_RD_LAT];
    logic [DW-1:0]   fifo_data [P_FIFO_DEPTH];
    logic [AW-1:0]   fifo_idx  [P_FIFO_DEPTH];

    logic            start;
    logic            credit_ok;
    logic            issue;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            drain_done;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) begin
            r[b] = a[AW-1-b];
        end
        return r;
    endfunction

    // Handshake, credit and issue decode shared by the FSM and datapath.
    // Outstanding reads (in flight + buffered) never exceed the FIFO depth,
    // so a returning beat always finds a free FIFO slot.
    always_comb begin
        fifo_empty = (fifo_cnt == '0);
        start      = (state == ST_IDLE) && pcm_data_rdy_oh && fetch_en;
        credit_ok  = ({1'b0, fifo_cnt} + {1'b0, inflight_cnt}) < (CW+1)'(P_FIFO_DEPTH);
        issue      = (state == ST_FETCH) && credit_ok;
        push       = pipe_vld[P_RD_LAT-1];
        pop        = !fifo_empty && smpl_ready;
        drain_done = (state == ST_DRAIN) && (inflight_cnt == '0) && fifo_empty;
        mem_rden   = issue;
        mem_addr   = rev_f ? bitrev(rd_ptr) : rd_ptr;
        busy       = (state != ST_IDLE);
        smpl_valid = !fifo_empty;
        smpl_data  = fifo_empty ? '0 : fifo_data[rd_pos];
        smpl_idx   = fifo_empty ? '0 : fifo_idx[rd_pos];
        smpl_last  = !fifo_empty && (fifo_idx[rd_pos] == LAST_IDX);
    end

    // Next-state logic: fetch until the last address is issued, then drain.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_FETCH;
            ST_FETCH: if (issue && (rd_ptr == LAST_IDX)) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Read pointer, order latch, credit counters, frame counter, error pulse.
    // rd_ptr parks at N-1 after the last issue; only a frame start clears it.
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            rd_ptr       <= '0;
            rev_f        <= 1'b0;
            inflight_cnt <= '0;
            fifo_cnt     <= '0;
            wr_pos       <= '0;
            rd_pos       <= '0;
            frame_cnt    <= '0;
            ovrn_err_oh  <= 1'b0;
            for (int k = 0; k < P_RD_LAT; k++) pipe_vld[k] <= 1'b0;
        end else begin
            if (start) begin
                rd_ptr <= '0;
                rev_f  <= bit_rev_en;
            end else if (issue && (rd_ptr != LAST_IDX)) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            inflight_cnt <= inflight_cnt + CW'(issue) - CW'(push);
            fifo_cnt     <= fifo_cnt + CW'(push) - CW'(pop);
            if (push) wr_pos <= wr_pos + PW'(1);
            if (pop)  rd_pos <= rd_pos + PW'(1);
            if (drain_done) frame_cnt <= frame_cnt + 16'd1;
            ovrn_err_oh <= pcm_data_rdy_oh && fetch_en && (state != ST_IDLE);
            pipe_vld[0] <= issue;
            for (int k = 1; k < P_RD_LAT; k++) pipe_vld[k] <= pipe_vld[k-1];
        end
    end

    // Tag pipeline and FIFO storage; contents are qualified by the valid bits
    // and counters above, so they need no reset.
    always_ff @(posedge clk_ir) begin
        pipe_idx[0] <= rd_ptr;
        for (int k = 1; k < P_RD_LAT; k++) pipe_idx[k] <= pipe_idx[k-1];
        if (push) begin
            fifo_data[wr_pos] <= mem_rdata;
            fifo_idx[wr_pos]  <= pipe_idx[P_RD_LAT-1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_syn_acache_fetch_sqncr.sv
`default_nettype none
// ============================================================================
// Module   : tb_syn_acache_fetch_sqncr
// Purpose  : Self-checking bench for syn_acache_fetch_sqncr: table-driven
//            frames plus hand-written corner sequences, all checked against
//            a frame-level reference model and a latency-accurate RAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_syn_acache_fetch_sqncr;

    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int N     = 128;

    logic          clk = 1'b0;
    logic          rst_il;
    logic          pcm_data_rdy_oh;
    logic          fetch_en;
    logic          bit_rev_en;
    logic          mem_rden;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] smpl_data;
    logic [AW-1:0] smpl_idx;
    logic          smpl_last;
    logic          smpl_valid;
    logic          smpl_ready;
    logic          busy;
    logic          ovrn_err_oh;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    syn_acache_fetch_sqncr #(
        .P_PCM_RAM_ADDR_W(AW), .P_PCM_RAM_DATA_W(DW),
        .P_RD_LAT(LAT), .P_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_ir(clk), .rst_il(rst_il), .pcm_data_rdy_oh(pcm_data_rdy_oh),
        .fetch_en(fetch_en), .bit_rev_en(bit_rev_en), .mem_rden(mem_rden),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .smpl_data(smpl_data),
        .smpl_idx(smpl_idx), .smpl_last(smpl_last), .smpl_valid(smpl_valid),
        .smpl_ready(smpl_ready), .busy(busy), .ovrn_err_oh(ovrn_err_oh),
        .frame_cnt(frame_cnt)
    );

    // Cache port B model: data appears LAT cycles after the read strobe,
    // garbage otherwise.
    logic [DW-1:0] cache [N];
    logic [DW-1:0] rd_q  [LAT];
    always @(posedge clk) begin
        rd_q[0] <= mem_rden ? cache[mem_addr] : DW'($urandom);
        for (int k = 1; k < LAT; k++) rd_q[k] <= rd_q[k-1];
    end
    assign mem_rdata = rd_q[LAT-1];

    int checks = 0, failures = 0, cyc = 0;
    int issue_k, exp_k, outstanding, ready_pct, exp_frames, ovrn_seen;
    int pulse_cyc, first_rden_cyc, first_valid_cyc, first_acc_cyc, last_acc_cyc;
    int addr_log [N];
    bit frame_active, cur_rev, stall_pending;
    logic [DW-1:0] held_data;
    logic [AW-1:0] held_idx;

    typedef struct {
        bit rev;
        int ready_pct;
        bit ident;
        int addr1;
        int addr2;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Address the k-th read of a frame must use, by arithmetic digit reversal.
    function automatic int exp_addr(input bit rev, input int j);
        int r = 0;
        int v = j;
        if (!rev) return j;
        for (int b = 0; b < AW; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic fill_cache(input bit ident);
        for (int i = 0; i < N; i++) cache[i] = ident ? DW'(i) : DW'($urandom);
    endtask

    // One clock of stimulus and observation, at the falling edge.
    task automatic tick(input bit pulse);
        @(negedge clk);
        cyc++;
        pcm_data_rdy_oh = pulse;
        if (stall_pending) begin
            chk("stall_valid", 64'(smpl_valid), 64'(1));
            chk("stall_data", 64'(smpl_data), 64'(held_data));
            chk("stall_idx", 64'(smpl_idx), 64'(held_idx));
        end
        smpl_ready = ($urandom_range(99) < ready_pct);
        if (ovrn_err_oh) ovrn_seen++;
        if (mem_rden) begin
            if (frame_active && issue_k < N) begin
                if (first_rden_cyc < 0) first_rden_cyc = cyc;
                addr_log[issue_k] = int'(mem_addr);
                chk("rd_addr", 64'(mem_addr), 64'(exp_addr(cur_rev, issue_k)));
                issue_k++;
                outstanding++;
            end else begin
                chk("spurious_rden", 64'(mem_rden), 64'(0));
            end
        end
        if (smpl_valid && frame_active && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (smpl_valid && smpl_ready) begin
            if (frame_active && exp_k < N) begin
                chk("smpl_idx", 64'(smpl_idx), 64'(exp_k));
                chk("smpl_data", 64'(smpl_data), 64'(cache[exp_addr(cur_rev, exp_k)]));
                chk("smpl_last", 64'(smpl_last), 64'(exp_k == N-1));
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                exp_k++;
                outstanding--;
            end else begin
                chk("spurious_sample", 64'(smpl_valid), 64'(0));
            end
        end
        if (mem_rden) chk("credit_bound", 64'(outstanding <= DEPTH), 64'(1));
        stall_pending = smpl_valid && !smpl_ready;
        held_data = smpl_data;
        held_idx  = smpl_idx;
    endtask

    task automatic start_frame(input bit rev);
        bit_rev_en      = rev;
        cur_rev         = rev;
        issue_k         = 0;
        exp_k           = 0;
        frame_active    = 1'b1;
        first_rden_cyc  = -1;
        first_valid_cyc = -1;
        first_acc_cyc   = -1;
        tick(1'b1);
        pulse_cyc = cyc;
    endtask

    task automatic wait_samples(input int target, input string name);
        int n = 0;
        while (exp_k < target && n < 5000) begin
            tick(1'b0);
            n++;
        end
        chk({name, "_progress"}, 64'(exp_k), 64'(target));
    endtask

    task automatic close_frame(input string name);
        repeat (3) tick(1'b0);
        exp_frames = (exp_frames + 1) & 16'hFFFF;
        chk({name, "_busy"}, 64'(busy), 64'(0));
        chk({name, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_mem"}, {55'd0, mem_rden, mem_addr, busy}, 64'(0));
        chk({name, "_smpl"}, {23'd0, smpl_valid, smpl_data, smpl_idx, smpl_last}, 64'(0));
        chk({name, "_stat"}, {47'd0, ovrn_err_oh, frame_cnt}, 64'(0));
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 100, 1'b1, 1, 2};
        vecs[1] = '{1'b1, 100, 1'b1, 64, 32};
        vecs[2] = '{1'b0, 30, 1'b0, 1, 2};
        vecs[3] = '{1'b1, 30, 1'b0, 64, 32};
        vecs[4] = '{1'b1, 60, 1'b0, 64, 32};
        vecs[5] = '{1'b0, 80, 1'b0, 1, 2};

        rst_il = 1'b0; pcm_data_rdy_oh = 1'b0; fetch_en = 1'b0;
        bit_rev_en = 1'b0; smpl_ready = 1'b0; ready_pct = 100;
        issue_k = N; exp_k = N; outstanding = 0; exp_frames = 0; ovrn_seen = 0;
        frame_active = 1'b0; cur_rev = 1'b0; stall_pending = 1'b0;
        held_data = '0; held_idx = '0;
        pulse_cyc = 0; first_rden_cyc = -1; first_valid_cyc = -1;
        first_acc_cyc = -1; last_acc_cyc = -1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_il   = 1'b1;
        fetch_en = 1'b1;
        repeat (2) tick(1'b0);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            fill_cache(vecs[i].ident);
            ready_pct = vecs[i].ready_pct;
            start_frame(vecs[i].rev);
            wait_samples(N, "vec_frame");
            chk("vec_addr1", 64'(addr_log[1]), 64'(vecs[i].addr1));
            chk("vec_addr2", 64'(addr_log[2]), 64'(vecs[i].addr2));
            chk("vec_rden_lat", 64'(first_rden_cyc - pulse_cyc), 64'(1));
            chk("vec_valid_lat", 64'(first_valid_cyc - pulse_cyc), 64'(2 + LAT));
            if (vecs[i].ready_pct == 100)
                chk("vec_burst", 64'(last_acc_cyc - first_acc_cyc), 64'(N - 1));
            close_frame("vec");
        end

        // Order config changed mid-frame must not alter the running frame
        fill_cache(1'b0);
        ready_pct = 50;
        start_frame(1'b0);
        wait_samples(10, "revflip_a");
        bit_rev_en = 1'b1;
        wait_samples(N, "revflip_b");
        close_frame("revflip");

        // Disable mid-frame: frame completes, later pulses do nothing
        fill_cache(1'b0);
        start_frame(1'b1);
        wait_samples(30, "disable_a");
        fetch_en = 1'b0;
        wait_samples(N, "disable_b");
        close_frame("disable");
        frame_active = 1'b0;
        tick(1'b1);
        tick(1'b0);
        chk("disable_busy", 64'(busy), 64'(0));
        repeat (5) tick(1'b0);
        chk("disable_no_ovrn", 64'(ovrn_seen), 64'(0));
        fetch_en = 1'b1;

        // Overrun mid-frame
        fill_cache(1'b0);
        ready_pct = 100;
        start_frame(1'b0);
        wait_samples(50, "ovrn_a");
        tick(1'b1);
        tick(1'b0);
        chk("ovrn_pulse", 64'(ovrn_err_oh), 64'(1));
        tick(1'b0);
        chk("ovrn_one_cycle", 64'(ovrn_err_oh), 64'(0));
        wait_samples(N, "ovrn_b");
        close_frame("ovrn");

        // Pulse on the DRAIN->IDLE cycle is still an overrun
        start_frame(1'b1);
        wait_samples(N, "drainedge");
        tick(1'b1);
        chk("drainedge_busy", 64'(busy), 64'(1));
        tick(1'b0);
        chk("drainedge_ovrn", 64'(ovrn_err_oh), 64'(1));
        chk("drainedge_idle", 64'(busy), 64'(0));
        close_frame("drainedge");

        // Frame counter wrap
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        @(negedge clk);
        chk("wrap_preload", 64'(frame_cnt), 64'(16'hFFFF));
        exp_frames = 16'hFFFF;
        fill_cache(1'b0);
        ready_pct = 75;
        start_frame(1'b0);
        wait_samples(N, "wrap");
        close_frame("wrap");

        // Asynchronous reset mid-frame, then a clean restart
        fill_cache(1'b0);
        ready_pct = 70;
        start_frame(1'b1);
        wait_samples(20, "rstmid");
        #1 rst_il = 1'b0;
        #1 chk_all_zero("rstmid");
        frame_active = 1'b0; stall_pending = 1'b0; outstanding = 0; exp_frames = 0;
        repeat (2) @(negedge clk);
        rst_il = 1'b1;
        repeat (2) tick(1'b0);
        chk("rstmid_busy", 64'(busy), 64'(0));
        ready_pct = 100;
        start_frame(1'b0);
        wait_samples(N, "restart");
        close_frame("restart");

        // Random frames
        for (int i = 0; i < 3; i++) begin
            fill_cache(1'b0);
            ready_pct = $urandom_range(100, 20);
            start_frame(1'($urandom_range(1, 0)));
            wait_samples(N, "rand");
            close_frame("rand");
        end

        chk("ovrn_total", 64'(ovrn_seen), 64'(2));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
